// File: rtl/memory_interface.sv
// memory_interface: single-outstanding bus-to-memory bridge.
// The FSM walks IDLE -> ACCESS -> COMPLETE. Strobes and load pulses are registered.
// Optional feature macro MEM_TIMEOUT_EN: abort an access after MAX_WAIT wait cycles.
// A timed-out read returns open-bus data (all ones).
module memory_interface #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [DATA_WIDTH-1:0] reqData,
    output logic                  reqReady,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    output logic                  memRead,
    output logic                  memWrite,
    input  logic                  memReady,
    input  logic [DATA_WIDTH-1:0] memRData,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdLoad,
    output logic                  errTimeout
);

    localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    reqReady_q;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
    logic [DATA_WIDTH-1:0]   memWData_q;
    logic                    memRead_q;
    logic                    memWrite_q;
    logic [DATA_WIDTH-1:0]   rdData_q;
    logic                    rdLoad_q;
    logic                    errTimeout_q;
    logic                    write_q;
    logic [WW-1:0]           wait_q;
    logic [WW-1:0]           wait_d;

    // Saturating next value of the wait counter.
    always_comb begin
        wait_d = wait_q;
        if (wait_q == WW'(MAX_WAIT)) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + WW'(1);
        end
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            reqReady_q   <= 1'b1;
            memAddr_q    <= '0;
            memWData_q   <= '0;
            memRead_q    <= 1'b0;
            memWrite_q   <= 1'b0;
            rdData_q     <= '0;
            rdLoad_q     <= 1'b0;
            errTimeout_q <= 1'b0;
            write_q      <= 1'b0;
            wait_q       <= '0;
        end else begin
            rdLoad_q     <= 1'b0;
            errTimeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        memAddr_q  <= reqAddr;
                        memWData_q <= reqData;
                        write_q    <= reqWrite;
                        memRead_q  <= ~reqWrite;
                        memWrite_q <= reqWrite;
                        wait_q     <= '0;
                        reqReady_q <= 1'b0;
                        state_q    <= ACCESS;
                    end else begin
                        reqReady_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (memReady) begin
                        if (!write_q) begin
                            rdData_q <= memRData;
                        end else begin
                            rdData_q <= rdData_q;
                        end
                        rdLoad_q   <= ~write_q;
                        memRead_q  <= 1'b0;
                        memWrite_q <= 1'b0;
                        state_q    <= COMPLETE;
                    end else begin
                        wait_q <= wait_d;
`ifdef MEM_TIMEOUT_EN
                        // This cycle is the MAX_WAIT-th wait: give up with open-bus data.
                        if (wait_q == WW'(MAX_WAIT - 1)) begin
                            if (!write_q) begin
                                rdData_q <= '1;
                            end else begin
                                rdData_q <= rdData_q;
                            end
                            rdLoad_q     <= ~write_q;
                            errTimeout_q <= 1'b1;
                            memRead_q    <= 1'b0;
                            memWrite_q   <= 1'b0;
                            state_q      <= COMPLETE;
                        end else begin
                            state_q <= ACCESS;
                        end
`else
                        state_q <= ACCESS;
`endif
                    end
                end
                COMPLETE: begin
                    reqReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    memRead_q  <= 1'b0;
                    memWrite_q <= 1'b0;
                    reqReady_q <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign reqReady   = reqReady_q;
    assign memAddr    = memAddr_q;
    assign memWData   = memWData_q;
    assign memRead    = memRead_q;
    assign memWrite   = memWrite_q;
    assign rdData     = rdData_q;
    assign rdLoad     = rdLoad_q;
    assign errTimeout = errTimeout_q;

endmodule

// File: tb/tb_memory_interface.sv
// Directed testbench for memory_interface (default parameters).
module tb_memory_interface;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqValid;
    logic          reqWrite;
    logic [AW-1:0] reqAddr;
    logic [DW-1:0] reqData;
    logic          reqReady;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic          memRead;
    logic          memWrite;
    logic          memReady;
    logic [DW-1:0] memRData;
    logic [DW-1:0] rdData;
    logic          rdLoad;
    logic          errTimeout;

    int total = 0;
    int bad   = 0;

    memory_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
        .reqReady(reqReady),
        .memAddr(memAddr), .memWData(memWData), .memRead(memRead), .memWrite(memWrite),
        .memReady(memReady), .memRData(memRData),
        .rdData(rdData), .rdLoad(rdLoad), .errTimeout(errTimeout)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 16'h0000;
        reqData = 8'h00; memReady = 1'b0; memRData = 8'h00;
        step(); step();
        rst = 1'b0;
        step();
        // Reset / idle state
        check("rst_ready", reqReady, 1'b1);
        check("rst_rd", memRead, 1'b0);
        check("rst_wr", memWrite, 1'b0);
        check("rst_load", rdLoad, 1'b0);
        check("rst_rddata", rdData, 8'h00);
        check("rst_addr", memAddr, 16'h0000);
        check("rst_to", errTimeout, 1'b0);

        // Zero-wait read 0x1234 -> 0xA5
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h1234; memReady = 1'b1; memRData = 8'hA5;
        step();
        reqValid = 1'b0;
        check("rd_strobe", memRead, 1'b1);
        check("rd_nowr", memWrite, 1'b0);
        check("rd_addr", memAddr, 16'h1234);
        check("rd_busy", reqReady, 1'b0);
        check("rd_noload_early", rdLoad, 1'b0);
        step();
        check("rd_strobe_off", memRead, 1'b0);
        check("rd_load", rdLoad, 1'b1);
        check("rd_data", rdData, 8'hA5);
        check("rd_noto", errTimeout, 1'b0);
        step();
        check("rd_load_off", rdLoad, 1'b0);
        check("rd_ready_back", reqReady, 1'b1);
        check("rd_data_hold", rdData, 8'hA5);

        // Write 0x3C to 0x01FF with 3 wait cycles: memWrite high 4 cycles
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'h01FF; reqData = 8'h3C;
        memReady = 1'b0; memRData = 8'h77;
        step();
        reqValid = 1'b0;
        check("wr_strobe_1", memWrite, 1'b1);
        check("wr_nord", memRead, 1'b0);
        check("wr_wdata", memWData, 8'h3C);
        check("wr_addr", memAddr, 16'h01FF);
        step();
        check("wr_strobe_2", memWrite, 1'b1);
        step();
        check("wr_strobe_3", memWrite, 1'b1);
        step();
        check("wr_strobe_4", memWrite, 1'b1);
        check("wr_wdata_stable", memWData, 8'h3C);
        memReady = 1'b1;
        step();
        memReady = 1'b0;
        check("wr_strobe_off", memWrite, 1'b0);
        check("wr_noload", rdLoad, 1'b0);
        check("wr_rddata_kept", rdData, 8'hA5);
        step();
        check("wr_ready_back", reqReady, 1'b1);
        check("wr_noload_2", rdLoad, 1'b0);

        // Reset in the middle of a read access
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0055; memReady = 1'b0;
        step();
        reqValid = 1'b0;
        check("rr_strobe", memRead, 1'b1);
        step();
        check("rr_strobe_held", memRead, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_strobe_drop", memRead, 1'b0);
        check("rr_noload", rdLoad, 1'b0);
        check("rr_ready", reqReady, 1'b1);
        check("rr_rddata_clr", rdData, 8'h00);
        memReady = 1'b1;
        step();
        memReady = 1'b0;
        check("rr_noload_2", rdLoad, 1'b0);
        check("rr_idle_rd", memRead, 1'b0);

        // Back-to-back reads 0x0010 -> 0x11, 0x0011 -> 0x22 with reqValid held
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0010; memReady = 1'b1; memRData = 8'h11;
        step();
        check("bb_rd1", memRead, 1'b1);
        check("bb_addr1", memAddr, 16'h0010);
        reqAddr = 16'h0011;
        step();
        check("bb_load1", rdLoad, 1'b1);
        check("bb_data1", rdData, 8'h11);
        check("bb_nord_c", memRead, 1'b0);
        memRData = 8'h22;
        step();
        check("bb_idle_ready", reqReady, 1'b1);
        check("bb_idle_noload", rdLoad, 1'b0);
        check("bb_idle_nord", memRead, 1'b0);
        step();
        reqValid = 1'b0;
        check("bb_rd2", memRead, 1'b1);
        check("bb_addr2", memAddr, 16'h0011);
        check("bb_noload_a2", rdLoad, 1'b0);
        step();
        check("bb_load2", rdLoad, 1'b1);
        check("bb_data2", rdData, 8'h22);
        step();
        check("bb_ready_end", reqReady, 1'b1);
        check("bb_noload_end", rdLoad, 1'b0);
        check("bb_nord_end", memRead, 1'b0);

        // memReady stuck low on a read
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0BAD; memReady = 1'b0;
        step();
        reqValid = 1'b0;
        check("to_rd_1", memRead, 1'b1);
`ifdef MEM_TIMEOUT_EN
        for (int i = 2; i <= MW; i++) begin
            step();
            check("to_rd_wait", memRead, 1'b1);
            check("to_no_err_yet", errTimeout, 1'b0);
        end
        step();
        check("to_err", errTimeout, 1'b1);
        check("to_load", rdLoad, 1'b1);
        check("to_data", rdData, 8'hFF);
        check("to_rd_off", memRead, 1'b0);
        step();
        check("to_err_off", errTimeout, 1'b0);
        check("to_ready", reqReady, 1'b1);
`else
        for (int i = 0; i < 40; i++) begin
            step();
            check("hang_rd", memRead, 1'b1);
            check("hang_no_err", errTimeout, 1'b0);
            check("hang_noload", rdLoad, 1'b0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("hang_rst_rd", memRead, 1'b0);
        check("hang_rst_ready", reqReady, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
